systolic_array: RTL and testbench



---
 rtl/tpu_pkg.sv | 12 +
 rtl/tpumac.sv | 66 ++++++
 rtl/systolic_array.sv | 59 +++++
 tb/tb_systolic_array.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared widths, operand/accumulator types and saturation bounds for the systolic MAC array.
package tpu_pkg;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;

  typedef logic signed [BITS_AB-1:0] opnd_t;
  typedef logic signed [BITS_C-1:0]  acc_t;

  localparam acc_t ACC_MAX = acc_t'({1'b0, {(BITS_C-1){1'b1}}});
  localparam acc_t ACC_MIN = acc_t'({1'b1, {(BITS_C-1){1'b0}}});
endpackage

// File: rtl/tpumac.sv
// One output-stationary signed MAC cell: registers its operands for the neighbours and accumulates Ain*Bin.
// Define SYSTOLIC_SAT_EN to saturate the accumulate instead of wrapping.
module tpumac #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int BITS_C  = tpu_pkg::BITS_C
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);
  localparam int PW = 2*BITS_AB;

  logic signed [BITS_AB-1:0] a_reg, b_reg;
  logic signed [BITS_C-1:0]  acc, acc_nxt, prod_c;
  logic signed [PW-1:0]      prod;

  assign prod   = Ain * Bin;
  // Sign-extends or truncates the full product to the accumulator width
  assign prod_c = BITS_C'(prod);

`ifdef SYSTOLIC_SAT_EN
  localparam logic signed [BITS_C-1:0] SAT_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] SAT_MIN = {1'b1, {(BITS_C-1){1'b0}}};
  logic signed [BITS_C:0] sum;

  assign sum = (BITS_C+1)'(acc) + (BITS_C+1)'(prod_c);

  // Overflow only when the extra sum bit disagrees; its direction follows the product sign
  always_comb begin
    acc_nxt = sum[BITS_C-1:0];
    if (sum[BITS_C] != sum[BITS_C-1])
      acc_nxt = prod_c[BITS_C-1] ? SAT_MIN : SAT_MAX;
  end
`else
  always_comb begin
    acc_nxt = acc + prod_c;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else begin
      if (en) begin
        a_reg <= Ain;
        b_reg <= Bin;
      end
      // Preload wins over accumulate and is taken verbatim
      if (WrEn)    acc <= Cin;
      else if (en) acc <= acc_nxt;
    end
  end

  assign Aout = a_reg;
  assign Bout = b_reg;
  assign Cout = acc;
endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary MAC grid with row-addressed accumulator preload and readout.
// Define SYSTOLIC_SAT_EN for saturating accumulation in every cell.
module systolic_array #(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int BITS_C  = tpu_pkg::BITS_C,
  parameter int DIM     = tpu_pkg::DIM
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           WrEn,
  input  logic [DIM-1:0][BITS_AB-1:0]    A,
  input  logic [DIM-1:0][BITS_AB-1:0]    B,
  input  logic [DIM-1:0][BITS_C-1:0]     Cin,
  input  logic [$clog2(DIM)-1:0]         Crow,
  output logic [DIM-1:0][BITS_C-1:0]     Cout
);
  localparam int CW = $clog2(DIM);

  // a_w[r][c] / b_w[r][c] feed cell (r,c); the extra column/row catches the far-edge outputs
  logic [BITS_AB-1:0] a_w   [DIM][DIM+1];
  logic [BITS_AB-1:0] b_w   [DIM+1][DIM];
  logic [BITS_C-1:0]  acc_w [DIM][DIM];
  logic               unused_edge;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    assign a_w[r][0] = A[r];
    assign b_w[0][r] = B[r];
    for (genvar c = 0; c < DIM; c++) begin : g_col
      tpumac #(.BITS_AB(BITS_AB), .BITS_C(BITS_C)) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .WrEn (WrEn && (Crow == CW'(r))),
        .Ain  (a_w[r][c]),
        .Bin  (b_w[r][c]),
        .Cin  (Cin[c]),
        .Aout (a_w[r][c+1]),
        .Bout (b_w[r+1][c]),
        .Cout (acc_w[r][c])
      );
    end
  end

  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < DIM; i++)
      unused_edge = unused_edge ^ (^a_w[i][DIM]) ^ (^b_w[DIM][i]);
  end

  // Row select; a Crow matching no row reads 0
  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++)
      if (Crow == CW'(r))
        for (int c = 0; c < DIM; c++)
          Cout[c] = acc_w[r][c];
  end
endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for systolic_array: reset, MAC, skewed matrix products, preload, overflow, hold.
module tb_systolic_array;
  import tpu_pkg::*;

  localparam int N  = DIM;
  localparam int CW = $clog2(N);
`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [N-1:0][BITS_C-1:0] row_t;

  logic                      clk = 1'b0;
  logic                      rst_n, en, WrEn;
  logic [N-1:0][BITS_AB-1:0] A, B;
  logic [N-1:0][BITS_C-1:0]  Cin, Cout;
  logic [CW-1:0]             Crow;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_array #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn),
    .A(A), .B(B), .Cin(Cin), .Crow(Crow), .Cout(Cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t fill(int v);
    row_t f;
    for (int i = 0; i < N; i++) f[i] = BITS_C'(v);
    return f;
  endfunction

  task automatic chk_row(string tag, int r, row_t exp);
    Crow = CW'(r);
    #1;
    checks++;
    assert (Cout === exp) else begin
      failures++;
      $error("FAIL %s row=%0d observed=%h expected=%h", tag, r, Cout, exp);
    end
  endtask

  task automatic chk_cell(string tag, int r, int c, int exp);
    acc_t obs;
    Crow = CW'(r);
    #1;
    obs = Cout[c];
    checks++;
    assert (int'(obs) === exp) else begin
      failures++;
      $error("FAIL %s cell=(%0d,%0d) observed=%0d expected=%0d", tag, r, c, int'(obs), exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; WrEn = 1'b0; A = '0; B = '0; Cin = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Standard diagonal skew: row r / column c delayed by r / c cycles; ident selects A=I, else A=-1
  task automatic run_skewed(bit ident, bit b_index);
    for (int t = 0; t <= 3*N-3; t++) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = t - i;
        if (k >= 0 && k < N) begin
          A[i] = ident ? ((i == k) ? 8'sd1 : 8'sd0) : -8'sd1;
          B[i] = b_index ? BITS_AB'(k*8 + i) : 8'sd2;
        end else begin
          A[i] = '0;
          B[i] = '0;
        end
      end
      en = 1'b1;
      step();
    end
    en = 1'b0; A = '0; B = '0;
  endtask

  initial begin
    row_t exp;
    rst_n = 1'b0; en = 1'b0; WrEn = 1'b0; A = '0; B = '0; Cin = '0; Crow = '0;
    #2;
    for (int r = 0; r < N; r++) chk_row("reset_init", r, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Random activity, then asynchronous reset checked before the next edge
    for (int i = 0; i < 12; i++) begin
      en   = 1'($urandom_range(0, 1));
      WrEn = 1'($urandom_range(0, 1));
      Crow = CW'($urandom_range(0, N-1));
      A    = {$urandom, $urandom};
      B    = {$urandom, $urandom};
      Cin  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    en = 1'b0; WrEn = 1'b0;
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) chk_row("reset_mid", r, '0);
    step();
    rst_n = 1'b1;
    step();

    // Single MAC
    do_reset();
    A[0] = 8'sd3; B[0] = 8'sd4; en = 1'b1;
    step();
    A = '0; B = '0; en = 1'b0;
    exp = '0; exp[0] = 16'd12;
    chk_row("mac_single", 0, exp);
    for (int r = 1; r < N; r++) chk_row("mac_single_zero", r, '0);
    en = 1'b1;
    step();
    en = 1'b0;
    chk_row("mac_extra_en", 0, exp);

    // Identity x B(i*8+j)
    do_reset();
    run_skewed(1'b1, 1'b1);
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) exp[j] = BITS_C'(r*8 + j);
      chk_row("matmul_ident", r, exp);
    end

    // Hold with noisy operands
    for (int i = 0; i < 10; i++) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      Cin = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    A = '0; B = '0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) exp[j] = BITS_C'(r*8 + j);
      chk_row("hold", r, exp);
    end

    // All -1 x all 2
    do_reset();
    run_skewed(1'b0, 1'b0);
    for (int r = 0; r < N; r++) chk_row("matmul_neg", r, fill(-16));

    // Preload with en low
    do_reset();
    WrEn = 1'b1; Crow = 3'd2; Cin = fill(100);
    step();
    WrEn = 1'b0;
    chk_row("preload_row2", 2, fill(100));
    chk_row("preload_row0", 0, '0);
    chk_row("preload_row3", 3, '0);

    // Preload together with en
    WrEn = 1'b1; Crow = 3'd2; Cin = fill(5); en = 1'b1;
    for (int i = 0; i < N; i++) begin A[i] = 8'sd1; B[i] = 8'sd1; end
    step();
    WrEn = 1'b0; en = 1'b0; A = '0; B = '0;
    chk_row("simul_row2", 2, fill(5));
    exp = '0; exp[0] = 16'd1;
    chk_row("simul_row0", 0, exp);
    chk_row("simul_row1", 1, '0);

    // Positive overflow
    do_reset();
    WrEn = 1'b1; Crow = '0; Cin = fill(32767);
    step();
    WrEn = 1'b0; en = 1'b1; A[0] = 8'sd1; B[0] = 8'sd1;
    step();
    en = 1'b0; A = '0; B = '0;
    chk_cell("ovf_pos", 0, 0, SAT ? 32767 : -32768);
    chk_cell("ovf_pos_nbr", 0, 1, 32767);

    // Negative overflow
    do_reset();
    WrEn = 1'b1; Crow = '0; Cin = fill(-32768);
    step();
    WrEn = 1'b0; en = 1'b1; A[0] = -8'sd1; B[0] = 8'sd1;
    step();
    en = 1'b0; A = '0; B = '0;
    chk_cell("ovf_neg", 0, 0, SAT ? -32768 : 32767);
    chk_cell("ovf_neg_nbr", 0, 1, -32768);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
